serial_word_feeder: RTL and testbench
=====================================

# serial_word_feeder

Parallel-to-serial front end for the 1011 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `x`, which drives the detector's serial input. A one-word holding register lets consecutive words stream with no idle cycles between them, so overlapping patterns that span a word boundary are preserved. When idle, the block drives `x` = 0 and `x_valid` = 0.

## Interface
- WIDTH, 8, bits per word; legal range ≥ 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
- clk  input  1  Single clock; all state updates on posedge.
- reset  input  1  Asynchronous, active-high reset.
- din  input  WIDTH  Word to serialize.
- din_valid  input  1  `din` is valid this cycle.
- din_ready  output  1  Block can accept a word this cycle. Transfer occurs when `din_valid` and `din_ready` are both high at a posedge.
- x  output  1  Serial bit; feeds the detector input `x`.
- x_valid  output  1  `x` carries a word bit this cycle.
- busy  output  1  Shifting is in progress, or the holding register is occupied.

## Operation
- Storage:
  - Shift register `sr` (WIDTH bits).
  - Bit counter `cnt` (clog2(WIDTH) bits, counts 0..WIDTH-1).
  - Holding register `hold` with flag `hold_full`.
  - State machine with two states, IDLE and SHIFT.
- Outputs:
  - `din_ready` = !`hold_full`. It is a registered-state function and never depends combinationally on `din_valid`.
  - In SHIFT, `x` = MSB of `sr` when MSB_FIRST = 1, otherwise LSB of `sr`. `x_valid` = 1.
  - In IDLE, `x` = 0 and `x_valid` = 0.
  - `busy` = (state == SHIFT) || `hold_full`.
- `last` = (state == SHIFT) && (`cnt` == WIDTH-1).
- IDLE transitions:
  - Accept: load `din` into `sr`, `cnt` = 0, go to SHIFT.
  - No accept: remain in IDLE.
- SHIFT, not `last`: shift `sr` one position toward the output end, zero-filling, and `cnt` += 1. An accept writes `hold`, and `hold_full` = 1.
- SHIFT, `last`, priority in this order:
  1. `hold_full`: `sr` = `hold`, `cnt` = 0, `hold_full` = 0, remain in SHIFT. No accept is possible this cycle because `din_ready` = 0.
  2. Accept with `hold` empty: `sr` = `din`, `cnt` = 0, remain in SHIFT. `hold` is bypassed.
  3. Otherwise: go to IDLE and clear `cnt`.
- An accepted word is never dropped and never duplicated. Words are emitted in acceptance order.
- Reset, including mid-word:
  - State IDLE; `sr`, `cnt`, and `hold` = 0; `hold_full` = 0.
  - The partial word and any held word are discarded.
  - Outputs during and after reset: `x` = 0, `x_valid` = 0, `din_ready` = 1, `busy` = 0.

## Timing
- Latency: a word accepted at posedge k presents its first bit on `x` in the cycle following edge k. Its last bit appears in the cycle following edge k+WIDTH-1.
- Each word produces exactly WIDTH consecutive cycles of `x_valid` = 1.
- Throughput: with `din_valid` held high, `x_valid` stays high continuously with no gap at word boundaries. That is 1 bit per clock.
- Backpressure:
  - `din_ready` falls at the edge that fills `hold`.
  - It rises again at the `last` edge that moves `hold` into `sr`.
  - With sustained `din_valid`, `din_ready` is low for WIDTH-1 cycles per word after the first two words.
- Per-cycle behaviour of `din`: it is sampled only at accepting edges, so `din` may change freely while `din_ready` = 0.

## Test plan
- **Single word.** Reset, then WIDTH = 8, MSB_FIRST = 1, accept 8'b1011_0000 at edge 1. Required: `x` = 1,0,1,1,0,0,0,0 in cycles 2–9 with `x_valid` = 1. After that, `x_valid` = 0, `x` = 0, and `busy` = 0.
- **Back-to-back stream.** Hold `din_valid` high with 8'hB6 then 8'hD0. Required: 16 contiguous valid bits 1011_0110_1101_0000 with no gap. `din_ready` = 0 from the edge after the second accept until the `last` edge of 8'hB6.
- **Boundary accept with empty hold.** Present a word exactly on the `last` cycle of the current word. Required: direct load into `sr`, no idle cycle, and `hold_full` stays 0.
- **Reset mid-operation.** Assert `reset` asynchronously at bit 4 of 8'hFF while `hold` = 8'hAA. Required: `x` and `x_valid` go to 0 immediately, and `din_ready` = 1. After release, no bit of either word is ever emitted.
- **LSB-first order.** Set MSB_FIRST = 0 and accept 8'b0000_1101. Required: `x` = 1,0,1,1,0,0,0,0.
- **Detector chain.** Feed words 8'b1011_0110 then 8'b1100_0000 into the detector. Required: detector `y` pulses in the cycles after the bits at stream positions 4, 7 and 10. This confirms overlap across the word boundary is preserved.

Source files
------------

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: parallel-to-serial front end feeding the 1011 detector
module serial_word_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] sr_next;

    assign accept    = din_valid && !hold_full;
    assign last      = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign sr_next   = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
    assign din_ready = !hold_full;
    assign x_valid   = (state == SHIFT);
    assign x         = (state == SHIFT) && (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
    assign busy      = (state == SHIFT) || hold_full;

    // Shift engine: at a word boundary a held word wins over a bypass load so order is kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sr        <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr    <= din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last) begin
                        sr  <= sr_next;
                        cnt <= cnt + 1'b1;
                        if (accept) begin
                            hold      <= din;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        sr        <= hold;
                        cnt       <= '0;
                        hold_full <= 1'b0;
                    end else if (accept) begin
                        sr  <= din;
                        cnt <= '0;
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: directed checks of the word serializer, both bit orders
module tb_serial_word_feeder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din_m = '0, din_l = '0;
    logic       dv_m = 1'b0, dv_l = 1'b0;
    logic       rdy_m, x_m, xv_m, busy_m;
    logic       rdy_l, x_l, xv_l, busy_l;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .din(din_m), .din_valid(dv_m),
        .din_ready(rdy_m), .x(x_m), .x_valid(xv_m), .busy(busy_m)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .din(din_l), .din_valid(dv_l),
        .din_ready(rdy_l), .x(x_l), .x_valid(xv_l), .busy(busy_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends a then b on the MSB-first instance; b arrives right after a (held) or on a's last bit (bypass)
    task automatic stream2(input logic [7:0] a, input logic [7:0] b, input bit at_last,
                           output logic [15:0] bits, output logic [15:0] rdy, output logic [15:0] mask);
        logic [3:0] hist;
        hist = '0;
        bits = '0;
        rdy  = '0;
        mask = '0;
        din_m = a;
        dv_m  = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            check("stream_xv", 32'(xv_m), 32'd1);
            bits = {bits[14:0], x_m};
            rdy  = {rdy[14:0], rdy_m};
            hist = {hist[2:0], x_m};
            if (hist == 4'b1011) mask[i] = 1'b1;
            din_m = b;
            dv_m  = at_last ? (i == 7) : (i == 0);
            step();
        end
        dv_m = 1'b0;
        check("stream_end_xv", 32'(xv_m), 32'd0);
        check("stream_end_busy", 32'(busy_m), 32'd0);
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] bits, rdy, mask;
        logic        seen;
        #3;
        check("rst_x", 32'(x_m), 32'd0);
        check("rst_xv", 32'(xv_m), 32'd0);
        check("rst_ready", 32'(rdy_m), 32'd1);
        check("rst_busy", 32'(busy_m), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // single word 1011_0000
        w = 8'b1011_0000;
        din_m = w;
        dv_m  = 1'b1;
        step();
        dv_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("single_x", 32'(x_m), 32'(w[7-i]));
            check("single_xv", 32'(xv_m), 32'd1);
            step();
        end
        check("single_idle_x", 32'(x_m), 32'd0);
        check("single_idle_xv", 32'(xv_m), 32'd0);
        check("single_idle_busy", 32'(busy_m), 32'd0);
        step();

        // back-to-back via holding register
        stream2(8'hB6, 8'hD0, 1'b0, bits, rdy, mask);
        check("b2b_bits", 32'(bits), 32'hB6D0);
        check("b2b_ready", 32'(rdy), 32'h80FF);
        step();

        // word presented on the last bit goes straight into the shifter
        stream2(8'h9C, 8'h35, 1'b1, bits, rdy, mask);
        check("bypass_bits", 32'(bits), 32'h9C35);
        check("bypass_ready", 32'(rdy), 32'hFFFF);
        step();

        // detector chain: 1011 hits at stream positions 4, 7, 10
        stream2(8'b1011_0110, 8'b1100_0000, 1'b0, bits, rdy, mask);
        check("det_bits", 32'(bits), 32'hB6C0);
        check("det_hits", 32'(mask), 32'h0248);
        step();

        // reset mid-word with a held word pending
        din_m = 8'hFF;
        dv_m  = 1'b1;
        step();
        din_m = 8'hAA;
        step();
        dv_m = 1'b0;
        check("mid_busy", 32'(busy_m), 32'd1);
        check("mid_ready", 32'(rdy_m), 32'd0);
        step();
        step();
        step();
        check("mid_pre_xv", 32'(xv_m), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_x", 32'(x_m), 32'd0);
        check("mid_rst_xv", 32'(xv_m), 32'd0);
        check("mid_rst_ready", 32'(rdy_m), 32'd1);
        check("mid_rst_busy", 32'(busy_m), 32'd0);
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = seen | xv_m;
            step();
        end
        check("mid_after_xv", 32'(seen), 32'd0);
        check("mid_after_busy", 32'(busy_m), 32'd0);

        // LSB-first order
        din_l = 8'b0000_1101;
        dv_l  = 1'b1;
        step();
        dv_l = 1'b0;
        w = '0;
        seen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = {w[6:0], x_l};
            seen = seen & xv_l;
            step();
        end
        check("lsb_bits", 32'(w), 32'hB0);
        check("lsb_xv", 32'(seen), 32'd1);
        check("lsb_end_xv", 32'(xv_l), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
